// File: rtl/instr_issue_seq.sv
// instr_issue_seq: four-state instruction issue sequencer (IDLE/DECODE/EXEC/WB)
// with an 8 x 16-bit register bank (R0 hard-wired to zero).
// Optional feature macro: ISSUE_MULT_EN -- when defined, opcode 5 (MULT) is legal.
// When it is undefined, opcode 5 retires as illegal and is presented as 7.
module instr_issue_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  op_opcode,
    output logic [15:0] op_rg2,
    output logic [15:0] op_rg3,
    output logic [6:0]  op_imm,
    input  logic [15:0] op_d1,
    input  logic        op_mem_active,
    output logic        done,
    output logic        illegal,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] WB     = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] rf [NUM_REGS];
    logic [DATA_W-1:0] res_d1;
    logic              res_we;

    logic [2:0] opc_c;
    logic [2:0] rd_c;
    logic [2:0] rs_c;
    logic [2:0] rt_c;
    logic       legal_c;
    logic [2:0] issue_opc_c;
    logic       wr_en_c;

    // Field decode of the latched instruction and retirement write enable
    always_comb begin
        opc_c = instr_q[15:13];
        rd_c  = instr_q[12:10];
        rs_c  = instr_q[9:7];
        rt_c  = instr_q[6:4];
`ifdef ISSUE_MULT_EN
        legal_c     = (opc_c <= 3'd5);
        issue_opc_c = opc_c;
`else
        legal_c     = (opc_c <= 3'd4);
        // Disabled MULT is shown to the operator as another unsupported code
        issue_opc_c = (opc_c == 3'd5) ? 3'd7 : opc_c;
`endif
        wr_en_c = (state == WB) && res_we && legal_c && (rd_c != 3'd0);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (instr_valid) state_nx = DECODE;
            DECODE:  state_nx = EXEC;
            EXEC:    state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake and retirement flags, registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_ready <= 1'b1;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            instr_ready <= (state_nx == IDLE);
            done        <= (state_nx == WB);
            illegal     <= (state_nx == WB) && !legal_c;
        end
    end

    // Instruction latch, operand issue and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q   <= '0;
            op_opcode <= '0;
            op_rg2    <= '0;
            op_rg3    <= '0;
            op_imm    <= '0;
            res_d1    <= '0;
            res_we    <= 1'b0;
        end else begin
            if (state == IDLE && instr_valid) instr_q <= instr;
            if (state == DECODE) begin
                op_opcode <= issue_opc_c;
                op_rg2    <= rf[rs_c];
                op_rg3    <= rf[rt_c];
                op_imm    <= instr_q[6:0];
            end
            if (state == EXEC) begin
                res_d1 <= op_d1;
                res_we <= op_mem_active;
            end
        end
    end

    // Register bank; R0 is never written so it always reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) rf[i] <= '0;
        end else if (wr_en_c) begin
            rf[rd_c] <= res_d1;
        end
    end

    // Combinational debug read port
    always_comb begin
        dbg_data = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];
    end

endmodule
